// File: rtl/soc_addr_sched_pkg.sv
// Shared FSM state type, register indices and bit positions for the scan
// address scheduler (soc_system_addr_sched and its pick sub-module).
package soc_addr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_DWELL,
        ST_NEXT
    } state_e;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_DWELL  = 3'd1;
    localparam logic [2:0] REG_MASK   = 3'd2;
    localparam logic [2:0] REG_MANUAL = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int unsigned CTRL_RUN_BIT     = 0;
    localparam int unsigned CTRL_ONESHOT_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 2;

    localparam int unsigned STATUS_BUSY_BIT = 4;
    localparam int unsigned STATUS_DONE_BIT = 5;

endpackage

// File: rtl/soc_system_addr_sched_pick.sv
// Rotating priority encoder: first set mask bit strictly above cur, wrapping
// through bit 0; reports whether the search wrapped and whether mask is empty.
module soc_system_addr_sched_pick
    import soc_addr_sched_pkg::*;
(
    input  logic [7:0] mask,
    input  logic [2:0] cur,
    output logic [2:0] next_idx,
    output logic       wrapped,
    output logic       none
);

    always_comb begin : search
        logic [2:0] idx;
        idx      = '0;
        next_idx = cur;
        none     = 1'b1;
        // Offset 8 lands back on cur, so a single-bit mask finds itself.
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = cur + 3'(i);
            if (none && mask[idx]) begin
                next_idx = idx;
                none     = 1'b0;
            end
        end
        wrapped = !none && (next_idx <= cur);
    end

endmodule

// File: rtl/soc_system_addr_sched.sv
// Avalon-MM controlled scan address scheduler: register file, guard/dwell
// counters and scan FSM. Optional level irq via macro SOC_ADDR_SCHED_IRQ_EN.
module soc_system_addr_sched
    import soc_addr_sched_pkg::*;
#(
    parameter int unsigned DWELL_W      = 16,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [2:0]  out_port,
    output logic        out_valid
`ifdef SOC_ADDR_SCHED_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

    state_e               state_q, state_d;
    logic                 run_q, run_d;
    logic                 oneshot_q, oneshot_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [7:0]           mask_q, mask_d;
    logic [2:0]           manual_q, manual_d;
    logic                 done_q, done_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [3:0]           guard_cnt_q, guard_cnt_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [2:0]           out_port_q, out_port_d;
    logic                 out_valid_q, out_valid_d;
`ifdef SOC_ADDR_SCHED_IRQ_EN
    logic                 irq_en_q, irq_en_d;
    logic                 irq_q, irq_d;
`endif

    logic       wr_en;
    logic       busy;
    logic [2:0] pick_cur;
    logic [2:0] pick_next;
    logic       pick_wrapped;
    logic       pick_none;
    logic       unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign busy         = (state_q != ST_IDLE);
    assign unused_wdata = ^writedata;

    // From IDLE, searching above index 7 yields the lowest set mask bit.
    assign pick_cur = (state_q == ST_IDLE) ? 3'd7 : ptr_q;

    soc_system_addr_sched_pick u_pick (
        .mask     (mask_q),
        .cur      (pick_cur),
        .next_idx (pick_next),
        .wrapped  (pick_wrapped),
        .none     (pick_none)
    );

    always_comb begin
        run_d       = run_q;
        oneshot_d   = oneshot_q;
        dwell_d     = dwell_q;
        mask_d      = mask_q;
        manual_d    = manual_q;
        done_d      = done_q;
        state_d     = state_q;
        ptr_d       = ptr_q;
        guard_cnt_d = guard_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
`ifdef SOC_ADDR_SCHED_IRQ_EN
        irq_en_d    = irq_en_q;
`endif

        if (wr_en) begin
            case (address)
                REG_CTRL: begin
                    oneshot_d = writedata[CTRL_ONESHOT_BIT];
                    if (!writedata[CTRL_RUN_BIT]) begin
                        run_d = 1'b0;
                    end else if (mask_q != '0) begin
                        run_d = 1'b1;
                    end
`ifdef SOC_ADDR_SCHED_IRQ_EN
                    irq_en_d = writedata[CTRL_IRQ_EN_BIT];
`endif
                end
                REG_DWELL:  dwell_d  = writedata[DWELL_W-1:0];
                REG_MASK:   mask_d   = writedata[7:0];
                REG_MANUAL: manual_d = writedata[2:0];
                REG_STATUS: if (writedata[STATUS_DONE_BIT]) done_d = 1'b0;
                default: ;
            endcase
        end

        // FSM runs after the register writes so a same-cycle set of done wins.
        if (state_q == ST_IDLE) begin
            if (run_d && !pick_none) begin
                state_d     = ST_GUARD;
                ptr_d       = pick_next;
                guard_cnt_d = GUARD_LOAD;
            end
        end else if (!run_d) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_GUARD: begin
                    if (guard_cnt_q == '0) begin
                        state_d     = ST_DWELL;
                        dwell_cnt_d = dwell_q;
                    end else begin
                        guard_cnt_d = guard_cnt_q - 4'd1;
                    end
                end
                ST_DWELL: begin
                    if (dwell_cnt_q == '0) begin
                        state_d = ST_NEXT;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (pick_none) begin
                        run_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else if (pick_wrapped && oneshot_q) begin
                        done_d  = 1'b1;
                        run_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        ptr_d       = pick_next;
                        guard_cnt_d = GUARD_LOAD;
                        state_d     = ST_GUARD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        out_valid_d = (state_d == ST_IDLE) || (state_d == ST_DWELL);
        out_port_d  = (state_d == ST_IDLE) ? manual_d : ptr_d;
`ifdef SOC_ADDR_SCHED_IRQ_EN
        irq_d       = done_d && irq_en_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            run_q       <= 1'b0;
            oneshot_q   <= 1'b0;
            dwell_q     <= '0;
            mask_q      <= '0;
            manual_q    <= '0;
            done_q      <= 1'b0;
            ptr_q       <= '0;
            guard_cnt_q <= '0;
            dwell_cnt_q <= '0;
            out_port_q  <= '0;
            out_valid_q <= 1'b1;
`ifdef SOC_ADDR_SCHED_IRQ_EN
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            oneshot_q   <= oneshot_d;
            dwell_q     <= dwell_d;
            mask_q      <= mask_d;
            manual_q    <= manual_d;
            done_q      <= done_d;
            ptr_q       <= ptr_d;
            guard_cnt_q <= guard_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            out_port_q  <= out_port_d;
            out_valid_q <= out_valid_d;
`ifdef SOC_ADDR_SCHED_IRQ_EN
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
`endif
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            REG_CTRL: begin
                readdata[CTRL_RUN_BIT]     = run_q;
                readdata[CTRL_ONESHOT_BIT] = oneshot_q;
`ifdef SOC_ADDR_SCHED_IRQ_EN
                readdata[CTRL_IRQ_EN_BIT]  = irq_en_q;
`endif
            end
            REG_DWELL:  readdata[DWELL_W-1:0] = dwell_q;
            REG_MASK:   readdata[7:0]         = mask_q;
            REG_MANUAL: readdata[2:0]         = manual_q;
            REG_STATUS: begin
                readdata[2:0]             = out_port_q;
                readdata[STATUS_BUSY_BIT] = busy;
                readdata[STATUS_DONE_BIT] = done_q;
            end
            default: ;
        endcase
    end

    assign out_port  = out_port_q;
    assign out_valid = out_valid_q;
`ifdef SOC_ADDR_SCHED_IRQ_EN
    assign irq       = irq_q;
`endif

endmodule

// File: doc/soc_system_addr_sched.md
SOC_SYSTEM_ADDR_SCHED -- requirements
Module: soc_system_addr_sched

Interface
REQ-001 Parameter DWELL_W, default 16: width of the dwell counter and the DWELL register.
REQ-002 Parameter GUARD_CYCLES, default 2, range 1-15: blanking cycles between successive scan addresses.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 address  input  3  Avalon-MM slave register index.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  combinational read data, zero-extended; 0 for unmapped indices.
REQ-010 out_port  output  3  registered, driven 3-bit device address.
REQ-011 out_valid  output  1  registered; 1 while out_port is stable and usable.
REQ-012 irq  output  1  level interrupt; present only with SOC_ADDR_SCHED_IRQ_EN.

Function
REQ-013 Register map: 0 CTRL{bit0 RUN, bit1 ONESHOT, bit2 IRQ_EN}; 1 DWELL[DWELL_W-1:0]; 2 MASK[7:0]; 3 MANUAL[2:0]; 4 STATUS{[2:0] cur_addr, bit4 busy, bit5 done}.
REQ-014 Register writes take effect on the clock edge of the write; reads have zero wait states.
REQ-015 FSM states: IDLE, GUARD, DWELL, NEXT.
REQ-016 IDLE: out_port=MANUAL, out_valid=1, busy=0; MANUAL writes appear on out_port one cycle later.
REQ-017 IDLE->GUARD when RUN=1 and MASK!=0; pointer loads with the lowest set MASK bit.
REQ-018 A RUN=1 write while MASK=0 is ignored; RUN reads back 0.
REQ-019 GUARD: out_valid=0, out_port=pointer; lasts exactly GUARD_CYCLES cycles, then DWELL.
REQ-020 DWELL: out_valid=1, out_port=pointer; lasts DWELL+1 cycles (DWELL=0 gives 1 cycle), then NEXT.
REQ-021 NEXT (1 cycle, out_valid=0): pointer becomes the next set MASK bit strictly above pointer, wrapping to bit 0.
REQ-022 If the search wraps (next index <= current) and ONESHOT=1: set done, clear RUN, go to IDLE; otherwise go to GUARD.
REQ-023 A single-bit MASK revisits the same address each pass; when it wraps, the ONESHOT rule applies.
REQ-024 MASK or DWELL changes during a scan are sampled only in NEXT or on DWELL entry, never mid-dwell.
REQ-025 MASK becoming 0 mid-scan: at NEXT, clear RUN and go to IDLE; done is not set.
REQ-026 Software RUN=0 write mid-scan: FSM goes to IDLE on the following cycle; done is not set.
REQ-027 STATUS write with bit5=1 clears done; if the FSM sets done in the same cycle, the set wins.
REQ-028 busy=1 in GUARD, DWELL and NEXT.

Reset
REQ-029 reset_n=0 at a clock edge: all registers, the pointer and done become 0 and the FSM goes to IDLE.
REQ-030 Outputs after reset: out_port=0, out_valid=1, readdata combinational from cleared registers, irq=0.
REQ-031 Reset asserted mid-scan aborts the scan immediately, with no further GUARD or DWELL cycles.

Configuration
REQ-032 Macro SOC_ADDR_SCHED_IRQ_EN defined: irq = done AND IRQ_EN, registered.
REQ-033 Macro undefined: no irq port; CTRL bit2 reads 0 and ignores writes; done stays readable via STATUS.

Structure
REQ-034 Shared package soc_addr_sched_pkg holds the FSM state enum, the register index constants (0-4) and the CTRL/STATUS bit positions.
REQ-035 Sub-module soc_system_addr_sched_pick: combinational 8-bit rotate priority encoder returning {next index, wrapped, none}.
REQ-036 The top level holds the register file, dwell/guard counters and FSM; no other sub-modules.

Verification
REQ-037 Reset, then write MANUAL=5 -> out_port=5 and out_valid=1 one cycle after the write; STATUS=0x5.
REQ-038 MASK=0x0A, DWELL=3, GUARD_CYCLES=2, CTRL=0x3 -> out_port 1 valid 4 cycles, 3 valid 4 cycles, then IDLE with done=1 and RUN=0.
REQ-039 MASK=0x81, ONESHOT=0, DWELL=0 -> continuous sequence 0,7,0,7 with valid pulses 1 cycle wide and GUARD+NEXT gaps of 3 cycles.
REQ-040 Running scan, write CTRL=0 during DWELL -> IDLE next cycle, out_port=MANUAL, done=0.
REQ-041 MASK=0 then CTRL=0x1 -> CTRL reads 0 and busy stays 0; in a second run, done set and STATUS bit5 W1C in the same cycle -> done=1.
REQ-042 With SOC_ADDR_SCHED_IRQ_EN and IRQ_EN=1, complete a oneshot scan -> irq=1 until W1C of done; reset_n=0 mid-DWELL -> out_port=0 and out_valid=1 next cycle.
